// File: rtl/muldiv_seq.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers, one bit per clock.
// Define MULDIV_SIGNED_EN for signed (MIPS-style) mult/div; the default build is unsigned.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        divzero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t      state;
  logic [4:0]  count;
  logic        op_r;
  logic        dz_r;
  logic [63:0] acc;   // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd;  // multiplicand or divisor magnitude

  logic [31:0] mag_a;
  logic [31:0] mag_b;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;

  logic [31:0] res_hi;
  logic [31:0] res_lo;

`ifdef MULDIV_SIGNED_EN
  logic sign_a;
  logic sign_x;

  always_comb begin
    mag_a = a[31] ? (32'd0 - a) : a;
    mag_b = b[31] ? (32'd0 - b) : b;
  end
`else
  always_comb begin
    mag_a = a;
    mag_b = b;
  end
`endif

  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
  end

  // The remainder never exceeds the divisor, so a 33-bit shifted value
  // with its top bit set always subtracts successfully.
  always_comb begin
    div_shift = acc[63:31];
    div_ge    = (div_shift >= {1'b0, opnd});
    div_sub   = div_shift[31:0] - opnd;
    div_next  = div_ge ? {div_sub, acc[30:0], 1'b1}
                       : {div_shift[31:0], acc[30:0], 1'b0};
  end

`ifdef MULDIV_SIGNED_EN
  logic [63:0] neg_acc;

  always_comb begin
    neg_acc = 64'd0 - acc;
    res_hi  = acc[63:32];
    res_lo  = acc[31:0];
    if (!dz_r) begin
      if (op_r) begin
        res_lo = sign_x ? (32'd0 - acc[31:0])  : acc[31:0];
        res_hi = sign_a ? (32'd0 - acc[63:32]) : acc[63:32];
      end else if (sign_x) begin
        res_hi = neg_acc[63:32];
        res_lo = neg_acc[31:0];
      end
    end
  end
`else
  always_comb begin
    res_hi = acc[63:32];
    res_lo = acc[31:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 5'd0;
      op_r    <= 1'b0;
      dz_r    <= 1'b0;
      acc     <= 64'd0;
      opnd    <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
`ifdef MULDIV_SIGNED_EN
      sign_a  <= 1'b0;
      sign_x  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            count   <= 5'd0;
            divzero <= 1'b0;
            busy    <= 1'b1;
`ifdef MULDIV_SIGNED_EN
            sign_a  <= a[31];
            sign_x  <= a[31] ^ b[31];
`endif
            if (op && (b == 32'd0)) begin
              // Raw dividend is parked in acc so FINISH can emit it unchanged.
              acc   <= {a, 32'hFFFF_FFFF};
              dz_r  <= 1'b1;
              state <= FINISH;
            end else begin
              acc   <= op ? {32'd0, mag_a} : {32'd0, mag_b};
              opnd  <= op ? mag_b : mag_a;
              dz_r  <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= op_r ? div_next : mul_next;
          count <= count + 5'd1;
          if (count == 5'd31)
            state <= FINISH;
        end
        FINISH: begin
          hi      <= res_hi;
          lo      <= res_lo;
          divzero <= dz_r;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
